// File: rtl/i2s_stereo_rx.sv
// i2s_stereo_rx: I2S master receiver for the stereo MEMS microphone pair.
// Generates SCK and WS from clk and shifts in i2s_sd. Each frame it keeps
// DATA_WIDTH MSB-aligned bits from the left and right slots and presents
// both samples together with a one-cycle data_valid strobe.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | enable low: counters parked at 0, sck/ws low, outputs hold
// RUN   | counters free-run, slot bits shift in, strobe at frame end
module i2s_stereo_rx #(
  parameter int DATA_WIDTH = 16,
  parameter int SLOT_BITS  = 32,
  parameter int SCK_DIV    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  i2s_sd,
  output logic                  i2s_sck,
  output logic                  i2s_ws,
  output logic [DATA_WIDTH-1:0] left_data_out,
  output logic [DATA_WIDTH-1:0] right_data_out,
  output logic                  data_valid
);

  localparam int DIV_W = $clog2(SCK_DIV);
  localparam int BIT_W = $clog2(2 * SLOT_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(SCK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(2 * SLOT_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT_LAST = BIT_W'(SLOT_BITS - 1);
  localparam logic [BIT_W-1:0] L_FIRST   = BIT_W'(1);
  localparam logic [BIT_W-1:0] L_LAST    = BIT_W'(DATA_WIDTH);
  localparam logic [BIT_W-1:0] R_FIRST   = BIT_W'(SLOT_BITS + 1);
  localparam logic [BIT_W-1:0] R_LAST    = BIT_W'(SLOT_BITS + DATA_WIDTH);

  // Reject parameter sets that would break the sampling point or slot layout.
  if (SCK_DIV < 4 || (SCK_DIV % 2) != 0) begin : g_bad_div
    $error("i2s_stereo_rx: SCK_DIV must be even and >= 4");
  end
  if (SLOT_BITS <= DATA_WIDTH) begin : g_bad_slot
    $error("i2s_stereo_rx: SLOT_BITS must exceed DATA_WIDTH");
  end

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                state;
  logic [DIV_W-1:0]      div_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DIV_W-1:0]      div_nxt;
  logic [BIT_W-1:0]      bit_nxt;
  logic                  sd_q;
  logic [DATA_WIDTH-1:0] left_sr;
  logic [DATA_WIDTH-1:0] right_sr;
  logic                  tick;
  logic                  frame_end;
  logic                  cap_left;
  logic                  cap_right;

  // Decode the capture/frame-end points and work out the next counter values.
  // A frame that reaches its last edge always completes, even if enable
  // drops on that same edge; otherwise enable low parks the counters at 0.
  always_comb begin
    tick      = (div_cnt == DIV_LAST);
    frame_end = (state == RUN) && tick && (bit_cnt == BIT_LAST);
    cap_left  = (state == RUN) && tick &&
                (bit_cnt >= L_FIRST) && (bit_cnt <= L_LAST);
    cap_right = (state == RUN) && tick &&
                (bit_cnt >= R_FIRST) && (bit_cnt <= R_LAST);
    div_nxt   = '0;
    bit_nxt   = '0;
    if (enable && !frame_end) begin
      if (tick) begin
        bit_nxt = bit_cnt + BIT_W'(1);
      end else begin
        div_nxt = div_cnt + DIV_W'(1);
        bit_nxt = bit_cnt;
      end
    end
  end

  // Sequencer: counters, registered SCK/WS, shift registers and output latch.
  // SCK and WS are registered from the next counter values so they leave the
  // block glitch-free and exactly aligned with div_cnt / bit_cnt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      div_cnt        <= '0;
      bit_cnt        <= '0;
      sd_q           <= 1'b0;
      left_sr        <= '0;
      right_sr       <= '0;
      left_data_out  <= '0;
      right_data_out <= '0;
      data_valid     <= 1'b0;
      i2s_sck        <= 1'b0;
      i2s_ws         <= 1'b0;
    end else begin
      sd_q       <= i2s_sd;
      div_cnt    <= div_nxt;
      bit_cnt    <= bit_nxt;
      i2s_sck    <= (div_nxt >= DIV_HALF);
      i2s_ws     <= (bit_nxt > SLOT_LAST);
      data_valid <= frame_end;

      if (cap_left) begin
        left_sr <= {left_sr[DATA_WIDTH-2:0], sd_q};
      end
      if (cap_right) begin
        right_sr <= {right_sr[DATA_WIDTH-2:0], sd_q};
      end
      if (frame_end) begin
        left_data_out  <= left_sr;
        right_data_out <= right_sr;
      end

      case (state)
        IDLE: begin
          if (enable) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (!enable) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_stereo_rx.sv
// tb_i2s_stereo_rx: drives i2s_stereo_rx with a behavioural I2S microphone
// and scores every data_valid strobe against a queue of expected frames.
module tb_i2s_stereo_rx;

  localparam int DW      = 16;
  localparam int SLOT    = 32;
  localparam int DIV     = 4;
  localparam int FRAME   = 2 * SLOT * DIV;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic        fill;
  } mic_t;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    int          cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          i2s_sd = 1'b0;
  logic          i2s_sck;
  logic          i2s_ws;
  logic [DW-1:0] left_data_out;
  logic [DW-1:0] right_data_out;
  logic          data_valid;

  int   cyc = 0;
  int   en_cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  mic_t mic_q[$];
  exp_t exp_q[$];

  i2s_stereo_rx #(
    .DATA_WIDTH(DW),
    .SLOT_BITS (SLOT),
    .SCK_DIV   (DIV)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .i2s_sd        (i2s_sd),
    .i2s_sck       (i2s_sck),
    .i2s_ws        (i2s_ws),
    .left_data_out (left_data_out),
    .right_data_out(right_data_out),
    .data_valid    (data_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Microphone: changes data after each SCK falling edge; the bit after a WS
  // change is the delay bit, then DW data bits MSB-first, then fill bits.
  task automatic mic_model();
    int          idx = 0;
    bit          primed = 1'b0;
    logic        psck = 1'b0;
    logic        pws = 1'b0;
    logic [15:0] cl = '0;
    logic [15:0] cr = '0;
    logic [15:0] word;
    logic [3:0]  bsel;
    logic        fill = 1'b0;
    mic_t        m;
    forever begin
      @(negedge clk);
      if (reset || !enable) begin
        idx    = 0;
        primed = 1'b0;
      end else if (!primed) begin
        primed = 1'b1;
        idx    = 0;
        m = (mic_q.size() > 0) ? mic_q.pop_front() : '{16'h0, 16'h0, 1'b0};
        cl = m.l; cr = m.r; fill = m.fill;
      end else if (psck && !i2s_sck) begin
        if (i2s_ws != pws) begin
          idx = 0;
          if (!i2s_ws) begin
            m = (mic_q.size() > 0) ? mic_q.pop_front() : '{16'h0, 16'h0, 1'b0};
            cl = m.l; cr = m.r; fill = m.fill;
          end
        end else begin
          idx++;
        end
      end
      psck = i2s_sck;
      pws  = i2s_ws;
      word = i2s_ws ? cr : cl;
      if (primed && idx >= 1 && idx <= DW) begin
        bsel   = 4'(DW - idx);
        i2s_sd = word[bsel];
      end else begin
        i2s_sd = primed ? fill : 1'b0;
      end
    end
  endtask

  // Scoreboard: every strobe pops one expected frame; outputs must not move
  // without a strobe.
  task automatic monitor();
    logic [15:0] pl = '0;
    logic [15:0] pr = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (data_valid) begin
          if (exp_q.size() == 0) begin
            check_eq("unexpected_valid", 32'(data_valid), 32'h0);
          end else begin
            e = exp_q.pop_front();
            check_eq("left_data", 32'(left_data_out), 32'(e.l));
            check_eq("right_data", 32'(right_data_out), 32'(e.r));
            check_eq("strobe_cycle", 32'(cyc), 32'(e.cyc));
          end
        end else begin
          if (left_data_out !== pl) check_eq("left_hold", 32'(left_data_out), 32'(pl));
          if (right_data_out !== pr) check_eq("right_hold", 32'(right_data_out), 32'(pr));
        end
      end
      pl = left_data_out;
      pr = right_data_out;
    end
  endtask

  task automatic start_run();
    @(posedge clk);
    #2;
    en_cyc = cyc;
    enable = 1'b1;
  endtask

  task automatic stop_run();
    @(posedge clk);
    #2;
    enable = 1'b0;
  endtask

  // Frame k (0-based) after start_run strobes after edge FRAME*(k+1).
  task automatic push_frame(input logic [15:0] l, input logic [15:0] r,
                            input logic fill, input bit expect_it, input int k);
    mic_q.push_back('{l, r, fill});
    if (expect_it) exp_q.push_back('{l, r, en_cyc + FRAME * (k + 1)});
  endtask

  task automatic wait_drain(input int max_cyc);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(posedge clk);
      n++;
    end
    #2;
    check_eq("drain_timeout", 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    fork
      mic_model();
      monitor();
    join_none

    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check_eq("rst_left", 32'(left_data_out), 32'h0);
    check_eq("rst_right", 32'(right_data_out), 32'h0);
    check_eq("rst_valid", 32'(data_valid), 32'h0);
    check_eq("rst_sck", 32'(i2s_sck), 32'h0);
    check_eq("rst_ws", 32'(i2s_ws), 32'h0);
    reset = 1'b0;
    repeat (4) @(posedge clk);

    // Single frame plus SCK phase and WS alignment.
    start_run();
    push_frame(16'h1234, 16'hABCD, 1'b0, 1'b1, 0);
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #2;
      check_eq("sck_phase", 32'(i2s_sck), 32'(((cyc - en_cyc) % DIV) >= (DIV / 2)));
    end
    while (i2s_ws == 1'b0 && (cyc - en_cyc) < FRAME) begin
      @(posedge clk);
      #2;
    end
    check_eq("ws_rise_edge", 32'(cyc - en_cyc), 32'(FRAME / 2));
    while (i2s_ws == 1'b1 && (cyc - en_cyc) < 2 * FRAME) begin
      @(posedge clk);
      #2;
    end
    check_eq("ws_fall_edge", 32'(cyc - en_cyc), 32'(FRAME));
    wait_drain(2 * FRAME);
    stop_run();

    // Ignored slot bits, negative and extreme samples.
    start_run();
    push_frame(16'h0000, 16'h0000, 1'b1, 1'b1, 0);
    push_frame(16'h8001, 16'h7FFE, 1'b1, 1'b1, 1);
    push_frame(16'hFFFF, 16'h0001, 1'b0, 1'b1, 2);
    wait_drain(4 * FRAME);
    stop_run();

    // Abort mid-frame at bit_cnt 20 while SCK is high.
    start_run();
    push_frame(16'h1111, 16'h2222, 1'b0, 1'b1, 0);
    push_frame(16'h5555, 16'h6666, 1'b1, 1'b0, 1);
    while (cyc < en_cyc + FRAME + 20 * DIV + DIV / 2) begin
      @(posedge clk);
      #2;
    end
    check_eq("abort_sck_before", 32'(i2s_sck), 32'h1);
    enable = 1'b0;
    @(posedge clk);
    #2;
    check_eq("abort_sck", 32'(i2s_sck), 32'h0);
    check_eq("abort_ws", 32'(i2s_ws), 32'h0);
    repeat (2 * FRAME) @(posedge clk);
    #2;
    check_eq("abort_left_hold", 32'(left_data_out), 32'h1111);
    check_eq("abort_right_hold", 32'(right_data_out), 32'h2222);
    start_run();
    push_frame(16'h3333, 16'h4444, 1'b0, 1'b1, 0);
    wait_drain(2 * FRAME);
    stop_run();

    // Streaming: 90 back-to-back random frames.
    start_run();
    for (int k = 0; k < 90; k++) begin
      push_frame(16'($urandom), 16'($urandom), 1'($urandom), 1'b1, k);
    end
    wait_drain(91 * FRAME);
    stop_run();

    // Asynchronous reset mid-run, then restart as if freshly enabled.
    start_run();
    push_frame(16'hAAAA, 16'h5555, 1'b1, 1'b0, 0);
    repeat (100 + DIV / 2) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_eq("mid_rst_left", 32'(left_data_out), 32'h0);
    check_eq("mid_rst_right", 32'(right_data_out), 32'h0);
    check_eq("mid_rst_valid", 32'(data_valid), 32'h0);
    check_eq("mid_rst_sck", 32'(i2s_sck), 32'h0);
    check_eq("mid_rst_ws", 32'(i2s_ws), 32'h0);
    repeat (20) @(posedge clk);
    #2;
    check_eq("hold_rst_sck", 32'(i2s_sck), 32'h0);
    check_eq("hold_rst_ws", 32'(i2s_ws), 32'h0);
    en_cyc = cyc;
    push_frame(16'h0F0F, 16'hF0F0, 1'b0, 1'b1, 0);
    reset = 1'b0;
    wait_drain(2 * FRAME);
    stop_run();
    repeat (10) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
